// File: rtl/i2s_pkg.sv
// i2s_pkg: definitions shared by the I2S receive path.
//   I2S_DATA_W : bits captured per channel.
//   frame_t    : one stereo frame, left word in the upper half.
//   rx_state_t : receiver framing states.
package i2s_pkg;

   localparam int I2S_DATA_W = 24;

   typedef struct packed {
      logic [I2S_DATA_W-1:0] left;
      logic [I2S_DATA_W-1:0] right;
   } frame_t;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } rx_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous first-word-fall-through FIFO for received frames.
//   clk, rst     : clock and asynchronous active-high reset
//   push/wr_data : write request and data; dropped when full with no pop
//   pop          : remove head (ignored while empty)
//   clr_overrun  : clear the sticky drop flag
//   rd_data      : head entry, valid while !empty
//   empty, count : occupancy
//   overrun      : sticky, a push was dropped
module i2s_rx_fifo
   import i2s_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = frame_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       wr_data,
   input  logic                   pop,
   input  logic                   clr_overrun,
   output T                       rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   T            mem_r [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        full_s;
   logic        empty_s;
   logic        do_pop_s;
   logic        do_push_s;

   // Occupancy flags; a full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      do_pop_s  = pop && !empty_s;
      do_push_s = push && (!full_s || do_pop_s);
   end

   // Storage and wrap-around pointers (extra MSB distinguishes full from empty).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sticky drop flag; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (push && !do_push_s) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign empty   = empty_s;
   assign count   = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Deserializes codec ADC data into left/right words in
// the CLK domain and buffers completed stereo frames.
//   CLK, RESET        : system clock (>= 8x SCLK), async active-high reset
//   SCLK, LRCLK, Din  : codec bit clock, word clock (0 = left), serial data
//   frame_valid       : one-cycle pulse per completed frame
//   left_data/right_data : last completed frame
//   rd_en, rd_data, empty, count : FWFT frame FIFO, rd_data = {left, right}
//   overrun, clr_overrun : sticky frame-drop flag and its clear
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W     = I2S_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        SCLK,
   input  logic                        LRCLK,
   input  logic                        Din,
   output logic                        frame_valid,
   output logic [DATA_W-1:0]           left_data,
   output logic [DATA_W-1:0]           right_data,
   input  logic                        rd_en,
   output logic [2*DATA_W-1:0]         rd_data,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        overrun,
   input  logic                        clr_overrun
);

   localparam int                CNT_W   = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]  TOP_IDX = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        sclk_sync_r;
   logic [1:0]        lrclk_sync_r;
   logic [1:0]        din_sync_r;
   logic              sclk_hist_r;
   logic              lr_prev_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] left_hold_r;
   rx_state_t         state_r;
   rx_state_t         state_next_s;
   logic              bit_event_s;
   logic              boundary_s;
   logic              lr_s;
   logic              din_s;
   logic [CNT_W-1:0]  idx_s;
   logic              latch_left_s;
   logic              commit_s;

   // Two-flop synchronizers on all codec pins plus SCLK history for edge detection.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sclk_sync_r  <= 2'b00;
         lrclk_sync_r <= 2'b00;
         din_sync_r   <= 2'b00;
         sclk_hist_r  <= 1'b0;
      end else begin
         sclk_sync_r  <= {sclk_sync_r[0], SCLK};
         lrclk_sync_r <= {lrclk_sync_r[0], LRCLK};
         din_sync_r   <= {din_sync_r[0], Din};
         sclk_hist_r  <= sclk_sync_r[1];
      end
   end

   // Bit events and channel boundaries; LRCLK/Din come from the same stage as SCLK.
   always_comb begin
      bit_event_s = sclk_sync_r[1] & ~sclk_hist_r;
      lr_s        = lrclk_sync_r[1];
      din_s       = din_sync_r[1];
      boundary_s  = bit_event_s && (lr_s != lr_prev_r);
      idx_s       = TOP_IDX - bit_cnt_r;
   end

   // Channel shifter: bits land left-justified so short slots zero-fill the LSBs.
   // The boundary bit belongs to the previous word and is dropped.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lr_prev_r <= 1'b0;
         bit_cnt_r <= '0;
         shift_r   <= '0;
      end else if (bit_event_s) begin
         lr_prev_r <= lr_s;
         if (boundary_s) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
         end else if (bit_cnt_r < CNT_MAX) begin
            shift_r   <= shift_r | ({{(DATA_W-1){1'b0}}, din_s} << idx_s);
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
         end
      end
   end

   // Framing state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r <= SYNC;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Framing next-state: a frame starts only at a right-to-left boundary.
   always_comb begin
      state_next_s = state_r;
      latch_left_s = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         SYNC: begin
            if (boundary_s && !lr_s) begin
               state_next_s = LEFT;
            end else begin
               state_next_s = SYNC;
            end
         end
         LEFT: begin
            if (boundary_s && lr_s) begin
               latch_left_s = 1'b1;
               state_next_s = RIGHT;
            end else begin
               state_next_s = LEFT;
            end
         end
         RIGHT: begin
            if (boundary_s && !lr_s) begin
               commit_s     = 1'b1;
               state_next_s = LEFT;
            end else begin
               state_next_s = RIGHT;
            end
         end
         default: begin
            state_next_s = SYNC;
         end
      endcase
   end

   // Left word holding register and frame output registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         left_hold_r <= '0;
         left_data   <= '0;
         right_data  <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= commit_s;
         if (latch_left_s) begin
            left_hold_r <= shift_r;
         end
         if (commit_s) begin
            left_data  <= left_hold_r;
            right_data <= shift_r;
         end
      end
   end

   i2s_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (logic [2*DATA_W-1:0])
   ) u_fifo (
      .clk         (CLK),
      .rst         (RESET),
      .push        (commit_s),
      .wr_data     ({left_hold_r, shift_r}),
      .pop         (rd_en),
      .clr_overrun (clr_overrun),
      .rd_data     (rd_data),
      .empty       (empty),
      .count       (count),
      .overrun     (overrun)
   );

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized self-checking bench for i2s_rx.
// Stimulus is generated one LRCLK half at a time (one boundary bit, then n word
// bits MSB-first). A half-level model predicts committed frames and their cycle;
// a FIFO queue model is compared against the DUT on every CLK cycle.
module tb_i2s_rx;
   import i2s_pkg::*;

   localparam int DW    = 24;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          SCLK = 1'b0;
   logic          LRCLK = 1'b0;
   logic          Din = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_overrun = 1'b0;
   logic          frame_valid;
   logic [DW-1:0] left_data;
   logic [DW-1:0] right_data;
   logic [2*DW-1:0] rd_data;
   logic          empty;
   logic [2:0]    count;
   logic          overrun;

   i2s_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .LRCLK(LRCLK), .Din(Din),
      .frame_valid(frame_valid), .left_data(left_data), .right_data(right_data),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct {
      int     cyc;
      frame_t f;
   } commit_t;

   int        n_checks = 0;
   int        n_err    = 0;
   int        cyc      = 0;
   logic      rd_q     = 1'b0;
   logic      clr_q    = 1'b0;
   commit_t   cq[$];
   frame_t    mq[$];
   logic [DW-1:0] m_ld   = '0;
   logic [DW-1:0] m_rdw  = '0;
   logic      m_over   = 1'b0;
   int        m_state  = 0;   // 0 waiting for a left start, 1 in left, 2 in right
   logic      m_prev   = 1'b0;
   logic [DW-1:0] m_left  = '0;
   logic [DW-1:0] m_right = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word captured from n bits held MSB-first in d[31 -: n]: first DW bits, zero-filled.
   function automatic logic [DW-1:0] cap(input logic [31:0] d, input int n);
      logic [31:0] m;
      m = (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
      d = d & m;
      return d[31:8];
   endfunction

   // Model reaction to the first bit event of a half.
   task automatic model_half_start(input logic lr, input logic [31:0] d, input int n, input int rise);
      commit_t c;
      if (lr != m_prev) begin
         if (!lr) begin
            if (m_state == 2) begin
               c.cyc = rise + 3;
               c.f.left = m_left;
               c.f.right = m_right;
               cq.push_back(c);
            end
            m_state = 1;
            m_left  = cap(d, n);
         end else if (m_state == 1) begin
            m_state = 2;
            m_right = cap(d, n);
         end
      end
      m_prev = lr;
   endtask

   // Send one LRCLK half; ev_kind 1 releases RESET, 2 pulses RESET for one CLK,
   // during the low phase of bit ev_bit. Starts and ends right after a negedge.
   task automatic send_half(input logic lr, input logic [31:0] d, input int n,
                            input int ev_bit, input int ev_kind, input bit pop_at_commit);
      for (int i = 0; i <= n; i++) begin
         SCLK  = 1'b0;
         LRCLK = lr;
         Din   = (i == 0) ? 1'($urandom_range(0, 1)) : d[32-i];
         for (int k = 0; k < 8; k++) begin
            if (i == ev_bit && ev_kind == 2 && k == 4) begin
               RESET = 1'b1;
               cq.delete();
               m_state = 0;
            end else if (i == ev_bit && ev_kind == 2 && k == 5) begin
               RESET  = 1'b0;
               m_prev = lr;
            end else if (i == ev_bit && ev_kind == 1 && k == 4) begin
               RESET   = 1'b0;
               m_state = 0;
               m_prev  = lr;
            end
            @(negedge CLK);
         end
         SCLK = 1'b1;
         if (i == 0 && !RESET) model_half_start(lr, d, n, cyc);
         for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (pop_at_commit && i == 0 && k == 1) rd_en = 1'b1;
            if (pop_at_commit && i == 0 && k == 2) rd_en = 1'b0;
         end
      end
   endtask

   task automatic send_frame_rand();
      send_half(1'b1, $urandom, $urandom_range(8, 24), -1, 0, 1'b0);
      send_half(1'b0, $urandom, $urandom_range(8, 24), -1, 0, 1'b0);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge CLK);
      rd_en = 1'b0;
   endtask

   // Cycle counter and capture of the synchronous controls seen at each edge.
   initial forever begin
      @(posedge CLK);
      cyc++;
      rd_q  = rd_en;
      clr_q = clr_overrun;
   end

   // Per-cycle comparison against the frame / FIFO model.
   initial forever begin
      logic   exp_fv;
      logic   do_pop;
      logic   can_push;
      frame_t nf;
      @(negedge CLK);
      #1;
      if (RESET) begin
         mq.delete();
         m_over = 1'b0;
         m_ld   = '0;
         m_rdw  = '0;
         chk("rst_frame_valid", frame_valid, 0);
         chk("rst_left_data", left_data, 0);
         chk("rst_right_data", right_data, 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_empty", empty, 1);
         chk("rst_count", count, 0);
         chk("rst_overrun", overrun, 0);
      end else begin
         exp_fv = 1'b0;
         nf = '0;
         if (cq.size() > 0 && cq[0].cyc == cyc) begin
            exp_fv = 1'b1;
            nf = cq.pop_front().f;
         end
         do_pop   = rd_q && (mq.size() > 0);
         can_push = (mq.size() < DEPTH) || do_pop;
         if (do_pop) void'(mq.pop_front());
         if (exp_fv) begin
            m_ld  = nf.left;
            m_rdw = nf.right;
            if (can_push) mq.push_back(nf);
         end
         if (exp_fv && !can_push) m_over = 1'b1;
         else if (clr_q) m_over = 1'b0;
         chk("frame_valid", frame_valid, exp_fv);
         chk("left_data", left_data, m_ld);
         chk("right_data", right_data, m_rdw);
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("overrun", overrun, m_over);
         if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
      end
   end

   initial begin
      @(negedge CLK);
      repeat (4) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chk("init_empty", empty, 1);
      chk("init_count", count, 0);

      // Basic capture, 32-bit slots with trailing ones, then short (16 data bit) slots.
      send_half(1'b1, 32'h0, 8, -1, 0, 1'b0);
      send_half(1'b0, {24'hABCDEF, 8'hFE}, 31, -1, 0, 1'b0);
      send_half(1'b1, {24'h123456, 8'hFE}, 31, -1, 0, 1'b0);
      send_half(1'b0, {16'h8001, 16'h0000}, 16, -1, 0, 1'b0);
      chk("basic_left", left_data, 64'hABCDEF);
      chk("basic_right", right_data, 64'h123456);
      chk("basic_rd_data", rd_data, 64'hABCDEF123456);
      chk("basic_count", count, 1);
      pop_one();
      send_half(1'b1, {16'h7FFF, 16'h0000}, 16, -1, 0, 1'b0);
      send_half(1'b0, $urandom, 20, -1, 0, 1'b0);
      chk("short_left", left_data, 64'h800100);
      chk("short_right", right_data, 64'h7FFF00);
      pop_one();

      // Overflow: five frames with no reads.
      for (int f = 0; f < 5; f++) send_frame_rand();
      chk("ovf_count", count, 4);
      chk("ovf_overrun", overrun, 1);
      for (int f = 0; f < 4; f++) pop_one();
      chk("ovf_drained_empty", empty, 1);
      clr_overrun = 1'b1;
      @(negedge CLK);
      clr_overrun = 1'b0;
      @(negedge CLK);
      chk("ovf_cleared", overrun, 0);

      // Full FIFO with a pop in the commit cycle.
      for (int f = 0; f < 4; f++) send_frame_rand();
      send_half(1'b1, $urandom, 12, -1, 0, 1'b0);
      send_half(1'b0, $urandom, 12, -1, 0, 1'b1);
      chk("full_popush_count", count, 4);
      chk("full_popush_overrun", overrun, 0);
      for (int f = 0; f < 4; f++) pop_one();

      // Randomized traffic with random reads.
      for (int f = 0; f < 8; f++) begin
         send_frame_rand();
         if ($urandom_range(0, 1) == 1) pop_one();
      end
      while (!empty) pop_one();

      // Reset pulse at left bit 10 with three frames buffered.
      send_frame_rand();
      send_frame_rand();
      send_half(1'b1, $urandom, 16, -1, 0, 1'b0);
      send_half(1'b0, $urandom, 24, 10, 2, 1'b0);
      chk("rstpulse_empty", empty, 1);
      chk("rstpulse_count", count, 0);
      send_half(1'b1, $urandom, 16, -1, 0, 1'b0);
      send_half(1'b0, $urandom, 16, -1, 0, 1'b0);
      chk("rstpulse_no_frame", count, 0);
      send_frame_rand();
      chk("rstpulse_first_frame", count, 1);
      pop_one();

      // Startup alignment: release reset in the middle of a right half.
      RESET = 1'b1;
      cq.delete();
      m_state = 0;
      send_half(1'b0, $urandom, 16, -1, 0, 1'b0);
      send_half(1'b1, $urandom, 16, 5, 1, 1'b0);
      send_half(1'b0, {24'h5A5A5A, 8'h00}, 24, -1, 0, 1'b0);
      send_half(1'b1, {24'h0F1E2D, 8'h00}, 24, -1, 0, 1'b0);
      chk("startup_no_frame", count, 0);
      send_half(1'b0, $urandom, 16, -1, 0, 1'b0);
      chk("startup_left", left_data, 64'h5A5A5A);
      chk("startup_right", right_data, 64'h0F1E2D);
      chk("startup_count", count, 1);

      repeat (10) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
